// File: rtl/knight_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | knight_pkg                                                         |
// | Shared FSM states, opcodes, headings and response bytes.           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package knight_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VERT   = 3'd1,
        WAIT_V = 3'd2,
        HORZ   = 3'd3,
        WAIT_H = 3'd4
    } state_t;

    localparam logic [3:0] OP_MOVE   = 4'h4;
    localparam logic [3:0] OP_MOVE_F = 4'h5;

    localparam logic [7:0] HEAD_PY = 8'h00;
    localparam logic [7:0] HEAD_NY = 8'h7F;
    localparam logic [7:0] HEAD_NX = 8'h3F;
    localparam logic [7:0] HEAD_PX = 8'hBF;

    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_NEXT = 8'h5A;
    localparam logic [7:0] RESP_BAD  = 8'hEE;
    localparam logic [7:0] RESP_WDOG = 8'hDD;

endpackage
`default_nettype wire

// File: rtl/knight_mv_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | knight_mv_decode                                                   |
// | One-hot knight move -> vertical and horizontal leg (heading, len). |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module knight_mv_decode
    import knight_pkg::*;
(
    input  logic [7:0] mv_i,
    output logic [7:0] vhead_o,
    output logic [1:0] vsq_o,
    output logic [7:0] hhead_o,
    output logic [1:0] hsq_o,
    output logic       invalid_o
);

    always_comb begin
        vhead_o   = HEAD_PY;
        vsq_o     = 2'd0;
        hhead_o   = HEAD_PX;
        hsq_o     = 2'd0;
        invalid_o = 1'b0;
        case (mv_i)
            8'h01: begin vsq_o = 2'd2; hsq_o = 2'd1; end
            8'h02: begin vsq_o = 2'd2; hhead_o = HEAD_NX; hsq_o = 2'd1; end
            8'h04: begin vsq_o = 2'd1; hhead_o = HEAD_NX; hsq_o = 2'd2; end
            8'h08: begin vhead_o = HEAD_NY; vsq_o = 2'd1; hhead_o = HEAD_NX; hsq_o = 2'd2; end
            8'h10: begin vhead_o = HEAD_NY; vsq_o = 2'd2; hhead_o = HEAD_NX; hsq_o = 2'd1; end
            8'h20: begin vhead_o = HEAD_NY; vsq_o = 2'd2; hsq_o = 2'd1; end
            8'h40: begin vhead_o = HEAD_NY; vsq_o = 2'd1; hsq_o = 2'd2; end
            8'h80: begin vsq_o = 2'd1; hsq_o = 2'd2; end
            default: invalid_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/knight_cmd_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | knight_cmd_gen                                                     |
// | Tour command initiator with UART passthrough; optional response    |
// | watchdog enabled by macro TOUR_WDOG_EN.                            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module knight_cmd_gen
    import knight_pkg::*;
#(
    parameter int NUM_MOVES = 24
`ifdef TOUR_WDOG_EN
    ,
    parameter int WDOG_CYC  = 2**22
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tour_go,
    output logic [4:0]  mv_indx,
    input  logic [7:0]  move,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        send_resp_out,
    output logic        usurp
);

    state_t      state_q, state_d;
    logic [4:0]  mv_indx_q, mv_indx_d;
    logic [7:0]  mv_reg_q, mv_reg_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic [7:0]  resp_q, resp_d;
    logic        resp_pls_q, resp_pls_d;

    logic [7:0]  w_dec_mv, w_vhead, w_hhead;
    logic [1:0]  w_vsq, w_hsq;
    logic        w_invalid, w_wdog_hit;

    // The first VERT cycle reads the store directly because mv_indx may have just advanced.
    assign w_dec_mv = (state_q == VERT && !cmd_rdy_q) ? move : mv_reg_q;

    knight_mv_decode u_dec (
        .mv_i      (w_dec_mv),
        .vhead_o   (w_vhead),
        .vsq_o     (w_vsq),
        .hhead_o   (w_hhead),
        .hsq_o     (w_hsq),
        .invalid_o (w_invalid)
    );

`ifdef TOUR_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYC + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d = '0;
        if (state_q == WAIT_V || state_q == WAIT_H)
            wdog_d = wdog_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) wdog_q <= '0;
        else        wdog_q <= wdog_d;
    end

    assign w_wdog_hit = (wdog_q == WDOG_W'(WDOG_CYC - 1));
`else
    assign w_wdog_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        mv_indx_d  = mv_indx_q;
        mv_reg_d   = mv_reg_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        resp_d     = resp_q;
        resp_pls_d = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_rdy_d = 1'b0;
                if (tour_go) begin
                    state_d  = VERT;
                    mv_reg_d = move;
                end
            end
            VERT: begin
                if (!cmd_rdy_q) begin
                    mv_reg_d = move;
                    if (w_invalid) begin
                        state_d    = IDLE;
                        mv_indx_d  = '0;
                        resp_d     = RESP_BAD;
                        resp_pls_d = 1'b1;
                    end else begin
                        cmd_d     = {OP_MOVE, w_vhead, 4'(w_vsq)};
                        cmd_rdy_d = 1'b1;
                    end
                end else if (clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    state_d   = WAIT_V;
                end
            end
            WAIT_V: begin
                if (send_resp) begin
                    state_d = HORZ;
                end else if (w_wdog_hit) begin
                    state_d    = IDLE;
                    mv_indx_d  = '0;
                    resp_d     = RESP_WDOG;
                    resp_pls_d = 1'b1;
                end
            end
            HORZ: begin
                if (!cmd_rdy_q) begin
                    cmd_d     = {OP_MOVE_F, w_hhead, 4'(w_hsq)};
                    cmd_rdy_d = 1'b1;
                end else if (clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    state_d   = WAIT_H;
                end
            end
            WAIT_H: begin
                if (send_resp) begin
                    resp_pls_d = 1'b1;
                    if (mv_indx_q == 5'(NUM_MOVES - 1)) begin
                        state_d   = IDLE;
                        mv_indx_d = '0;
                        resp_d    = RESP_ACK;
                    end else begin
                        state_d   = VERT;
                        mv_indx_d = mv_indx_q + 5'd1;
                        resp_d    = RESP_NEXT;
                    end
                end else if (w_wdog_hit) begin
                    state_d    = IDLE;
                    mv_indx_d  = '0;
                    resp_d     = RESP_WDOG;
                    resp_pls_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mv_indx_q  <= '0;
            mv_reg_q   <= '0;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            resp_q     <= RESP_ACK;
            resp_pls_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mv_indx_q  <= mv_indx_d;
            mv_reg_q   <= mv_reg_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            resp_q     <= resp_d;
            resp_pls_q <= resp_pls_d;
        end
    end

    // Tour responses are registered strobes; in IDLE processor responses pass straight through.
    assign usurp            = (state_q != IDLE);
    assign mv_indx          = mv_indx_q;
    assign cmd              = usurp ? cmd_q : cmd_UART;
    assign cmd_rdy          = usurp ? cmd_rdy_q : cmd_rdy_UART;
    assign clr_cmd_rdy_UART = usurp ? 1'b0 : clr_cmd_rdy;
    assign send_resp_out    = resp_pls_q | (!usurp & send_resp);
    assign resp             = resp_pls_q ? resp_q : RESP_ACK;

endmodule
`default_nettype wire
